// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register-file write port.
// Master modport is the requester/consumer side; slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] pending_mask;
  logic                last_grant;

  modport master (
    output a_valid, a_addr, a_data,
    output m_valid, m_addr, m_data,
    input  a_ready, m_ready,
    input  wr_en, wr_addr, wr_data, pending_mask, last_grant
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  m_valid, m_addr, m_data,
    output a_ready, m_ready,
    output wr_en, wr_addr, wr_data, pending_mask, last_grant
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (M) writebacks.
// Define REGFILE_WB_ZERO_DISCARD_EN to treat r0 as hardwired zero (writes to addr 0 are dropped).
//
// state  | meaning
// LAST_A | A was granted most recently; M wins the next tie
// LAST_M | M was granted most recently (reset value); A wins the next tie
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_M = 1'b1
  } last_e;

  last_e last_q, last_d;

  logic              a_full_q, a_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;

  logic              m_full_q, m_full_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic grant_a, grant_m;
  logic a_ready, m_ready;
  logic a_xfer, m_xfer;
  logic a_load, m_load;
  logic [NUM_REGS-1:0] mask;

  // Occupancy-only arbitration: a lone full buffer always wins, ties alternate.
  assign grant_a = a_full_q && (!m_full_q || (last_q == LAST_M));
  assign grant_m = m_full_q && (!a_full_q || (last_q == LAST_A));

  // Ready while draining keeps a single streaming requester at one write per cycle.
  assign a_ready = !a_full_q || grant_a;
  assign m_ready = !m_full_q || grant_m;

  assign a_xfer = bus.a_valid && a_ready;
  assign m_xfer = bus.m_valid && m_ready;

`ifdef REGFILE_WB_ZERO_DISCARD_EN
  // r0 writes complete the handshake but never occupy a buffer.
  assign a_load = a_xfer && (bus.a_addr != '0);
  assign m_load = m_xfer && (bus.m_addr != '0);
`else
  assign a_load = a_xfer;
  assign m_load = m_xfer;
`endif

  always_comb begin
    last_d    = last_q;
    a_full_d  = a_full_q;
    a_addr_d  = a_addr_q;
    a_data_d  = a_data_q;
    m_full_d  = m_full_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (grant_a) begin
      a_full_d  = 1'b0;
      wr_en_d   = 1'b1;
      wr_addr_d = a_addr_q;
      wr_data_d = a_data_q;
      last_d    = LAST_A;
    end else if (grant_m) begin
      m_full_d  = 1'b0;
      wr_en_d   = 1'b1;
      wr_addr_d = m_addr_q;
      wr_data_d = m_data_q;
      last_d    = LAST_M;
    end

    // A load on the same edge as a grant overrides the drain above.
    if (a_load) begin
      a_full_d = 1'b1;
      a_addr_d = bus.a_addr;
      a_data_d = bus.a_data;
    end
    if (m_load) begin
      m_full_d = 1'b1;
      m_addr_d = bus.m_addr;
      m_data_d = bus.m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= LAST_M;
      a_full_q  <= 1'b0;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      m_full_q  <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      last_q    <= last_d;
      a_full_q  <= a_full_d;
      a_addr_q  <= a_addr_d;
      a_data_q  <= a_data_d;
      m_full_q  <= m_full_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    mask = '0;
    if (a_full_q) mask[a_addr_q] = 1'b1;
    if (m_full_q) mask[m_addr_q] = 1'b1;
    if (wr_en_q)  mask[wr_addr_q] = 1'b1;
  end

  assign bus.a_ready      = a_ready;
  assign bus.m_ready      = m_ready;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.pending_mask = mask;
  assign bus.last_grant   = (last_q == LAST_M);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised + directed bench for regfile_wb_arbiter: a queue-based reference model predicts
// every write and handshake, a negedge monitor compares the DUT against it.
module tb_regfile_wb_arbiter;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one-deep queues per requester, a scoreboard of issued writes
  wr_t qa[$];
  wr_t qm[$];
  wr_t sb[$];
  bit  last_m = 1'b1;
  bit  exp_wr_en = 1'b0;
  logic [ADDR_W-1:0] exp_wr_addr = '0;
  logic [DATA_W-1:0] exp_wr_data = '0;
  bit  armed = 1'b0;

  // stimulus sources: items wait here until the DUT accepts them
  wr_t src_a[$];
  wr_t src_m[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_grant_a();
    return (qa.size() != 0) && ((qm.size() == 0) || last_m);
  endfunction

  function automatic bit model_grant_m();
    return !model_grant_a() && (qm.size() != 0);
  endfunction

  function automatic bit keeps(input logic [ADDR_W-1:0] addr);
`ifdef REGFILE_WB_ZERO_DISCARD_EN
    return addr != '0;
`else
    return addr == addr;
`endif
  endfunction

  function automatic logic [NUM_REGS-1:0] model_mask();
    logic [NUM_REGS-1:0] m;
    m = '0;
    foreach (qa[i]) m[qa[i].addr] = 1'b1;
    foreach (qm[i]) m[qm[i].addr] = 1'b1;
    if (exp_wr_en) m[exp_wr_addr] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin : model
    bit ga, gm, ra, rm;
    wr_t e;
    if (reset) begin
      qa.delete();
      qm.delete();
      sb.delete();
      last_m      = 1'b1;
      exp_wr_en   = 1'b0;
      exp_wr_addr = '0;
      exp_wr_data = '0;
      armed       = 1'b1;
    end else if (armed) begin
      ga = model_grant_a();
      gm = model_grant_m();
      ra = (qa.size() == 0) || ga;
      rm = (qm.size() == 0) || gm;
      exp_wr_en = ga || gm;
      if (ga) begin
        e = qa.pop_front();
        last_m = 1'b0;
      end
      if (gm) begin
        e = qm.pop_front();
        last_m = 1'b1;
      end
      if (ga || gm) begin
        sb.push_back(e);
        exp_wr_addr = e.addr;
        exp_wr_data = e.data;
      end
      if (bus.a_valid && ra && keeps(bus.a_addr)) begin
        e.addr = bus.a_addr;
        e.data = bus.a_data;
        qa.push_back(e);
      end
      if (bus.m_valid && rm && keeps(bus.m_addr)) begin
        e.addr = bus.m_addr;
        e.data = bus.m_data;
        qm.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : monitor
    wr_t e;
    if (armed) begin
      chk("a_ready", bus.a_ready, (qa.size() == 0) || model_grant_a());
      chk("m_ready", bus.m_ready, (qm.size() == 0) || model_grant_m());
      chk("pending_mask", bus.pending_mask, model_mask());
      chk("last_grant", bus.last_grant, last_m);
      chk("wr_en", bus.wr_en, exp_wr_en);
      if (bus.wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required=none", bus.wr_addr, bus.wr_data);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", bus.wr_addr, e.addr);
          chk("wr_data", bus.wr_data, e.data);
        end
      end else begin
        chk("wr_addr_hold", bus.wr_addr, exp_wr_addr);
        chk("wr_data_hold", bus.wr_data, exp_wr_data);
      end
    end
  end

  // Presents source heads each cycle; a head is retired only when the handshake completes.
  task automatic run(input int max_cyc, input int gap_pct, input bit must_drain);
    bit acc_a, acc_m;
    int cyc;
    cyc = 0;
    while ((src_a.size() != 0 || src_m.size() != 0) && cyc < max_cyc) begin
      bus.a_valid = (src_a.size() != 0) && ($urandom_range(99) >= gap_pct);
      bus.m_valid = (src_m.size() != 0) && ($urandom_range(99) >= gap_pct);
      bus.a_addr  = (src_a.size() != 0) ? src_a[0].addr : ADDR_W'($urandom);
      bus.a_data  = (src_a.size() != 0) ? src_a[0].data : $urandom;
      bus.m_addr  = (src_m.size() != 0) ? src_m[0].addr : ADDR_W'($urandom);
      bus.m_data  = (src_m.size() != 0) ? src_m[0].data : $urandom;
      acc_a = bus.a_valid && bus.a_ready;
      acc_m = bus.m_valid && bus.m_ready;
      @(posedge clk);
      #1;
      if (acc_a) void'(src_a.pop_front());
      if (acc_m) void'(src_m.pop_front());
      cyc++;
    end
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    if (must_drain && (src_a.size() != 0 || src_m.size() != 0)) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d left required=0/0", src_a.size(), src_m.size());
    end
  endtask

  task automatic idle(input int n);
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    src_a.delete();
    src_m.delete();
  endtask

  function automatic wr_t item(input int addr, input logic [DATA_W-1:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    return e;
  endfunction

  initial begin
    reset = 1'b1;
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    bus.a_addr = '0;
    bus.a_data = '0;
    bus.m_addr = '0;
    bus.m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // single A write to r5
    src_a.push_back(item(5, 32'h1234_5678));
    run(20, 0, 1);
    idle(4);

    // both streaming: odd addrs on A, even on M
    for (int i = 0; i < 7; i++) begin
      src_a.push_back(item(2 * i + 1, $urandom));
      src_m.push_back(item(2 * i + 2, $urandom));
    end
    run(60, 0, 1);
    idle(4);

    // A alone back-to-back
    for (int i = 1; i <= 8; i++) src_a.push_back(item(i, $urandom));
    run(20, 0, 1);
    idle(4);

    // same destination in both buffers, fresh reset so A has priority
    do_reset();
    src_a.push_back(item(7, 32'h0000_AAAA));
    src_m.push_back(item(7, 32'h0000_BBBB));
    run(20, 0, 1);
    idle(4);

    // reset while both buffers full and a write is staged
    for (int i = 0; i < 6; i++) begin
      src_a.push_back(item(i + 1, $urandom));
      src_m.push_back(item(i + 9, $urandom));
    end
    run(3, 0, 0);
    do_reset();
    idle(6);

    // write to r0 (discarded only when zero-discard is built in)
    src_m.push_back(item(0, 32'h0000_FFFF));
    run(20, 0, 1);
    idle(4);

    // randomised traffic with gaps and occasional mid-stream reset
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 40; i++) begin
        src_a.push_back(item($urandom_range(NUM_REGS - 1), $urandom));
        src_m.push_back(item($urandom_range(NUM_REGS - 1), $urandom));
      end
      if (round == 2) begin
        run($urandom_range(20, 5), 30, 0);
        do_reset();
      end else begin
        run(1000, 30, 1);
      end
      idle(3);
    end

    idle(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
